proc_run_controller: RTL and testbench
======================================

// Module: proc_run_controller
// PURPOSE
//  Top-level sequencer for the MIPS processor datapath. Flow: load a program into instruction memory.
//  Release PC reset and run until a halt word or cycle limit. Drain in-flight instructions.
//  Stream out the register file (and optionally data memory) over a valid/ready dump port.
//  Drives the imem write port, PC reset/write, and the debug read muxes of regfile and data memory.
// PARAMETERS
//  PROG_LEN_W   8             width of prog_len; max program = 2**PROG_LEN_W-1 words
//  MAX_CYCLES   16'd1000      RUN cycle limit before forced stop
//  HALT_WORD    32'h0000000C  fetched word that ends RUN (syscall)
//  DRAIN_CYCLES 4             cycles after stop before dumping (pipeline retire)
//  DMEM_WORDS   16            data-memory words dumped when DMEM_DUMP_EN
// PORTS
//  clk           in   1           rising-edge clock
//  reset         in   1           synchronous, active-high
//  start         in   1           begin load/run/dump sequence (sampled in IDLE/DONE)
//  prog_len      in   PROG_LEN_W  words to load; sampled with start
//  ld_valid      in   1           program source has word
//  ld_data       in   32          program word
//  ld_ready      out  1           controller accepts word
//  imem_addr     out  32          instr-mem init address (word index*4)
//  imem_wdata    out  32          instr-mem write data (= ld_data)
//  imem_write    out  1           instr-mem write enable
//  imem_read     out  1           instr-mem read enable
//  init_sel      out  1           1: imem address from imem_addr, 0: from PC
//  pc_reset      out  1           hold PC at 0
//  pc_write      out  1           PC load enable
//  instr         in   32          currently fetched instruction
//  rf_dbg_sel    out  1           regfile read port 1 driven by rf_dbg_addr
//  rf_dbg_addr   out  5           regfile debug address
//  rf_dbg_data   in   32          regfile read data (combinational)
//  dm_dbg_sel/dm_dbg_addr[31:0]/dm_dbg_data[31:0]  (out/out/in) data-mem debug read; DMEM_DUMP_EN only
//  dump_valid    out  1 ; dump_ready in 1 ; dump_data out 32 ; dump_idx out 8 (reg no. or mem word no.)
//  cycle_count   out  16          RUN cycles elapsed
//  busy / done / timeout  out 1 each
// BEHAVIOUR
//  Reset: state IDLE; pc_reset=1; all other outputs 0; counters 0. Reset mid-sequence aborts
//   next edge; imem/regfile contents untouched; partial dump abandoned.
//  IDLE: init_sel=1. start -> LOAD (prog_len!=0) or RUN (prog_len==0); busy=1 from next cycle.
//  LOAD: ld_ready=1, init_sel=1, pc_reset=1. Handshake ld_valid&ld_ready writes same cycle:
//   imem_write=1, imem_addr=widx*4, imem_wdata=ld_data; widx++. Word prog_len-1 accepted -> RUN.
//   No write without handshake; ld_valid low stalls indefinitely.
//  RUN: init_sel=0, pc_reset=0, pc_write=1, imem_read=1; cycle_count+1 per cycle (cleared on start).
//   instr==HALT_WORD -> DRAIN; cycle_count==MAX_CYCLES-1 -> DRAIN with timeout=1 (sticky to start).
//   Both same cycle: timeout=0.
//  DRAIN: pc_write=0, imem_read=1; DRAIN_CYCLES cycles, then -> DUMP_RF.
//  DUMP_RF: rf_dbg_sel=1, rf_dbg_addr=idx, dump_valid=1, dump_data=rf_dbg_data, dump_idx=idx.
//   Outputs stable while dump_valid&!dump_ready. Accept at idx 31 -> DUMP_DM or DONE.
//  DONE: done=1, busy=0, pc_reset=1. start restarts at LOAD/RUN; done clears next cycle.
//  start outside IDLE/DONE ignored. idx and widx never wrap within a state.
// CONFIGURATION
//  DMEM_DUMP_EN defined: after r31, DUMP_DM state streams words 0..DMEM_WORDS-1.
//   Uses dm_dbg_sel=1, dm_dbg_addr=idx*4; dump_idx restarts at 0; last accept -> DONE.
//  Undefined: dm_dbg_* ports absent; DUMP_RF -> DONE.
// STRUCTURE
//  Package proc_ctrl_pkg: state enum (IDLE,LOAD,RUN,DRAIN,DUMP_RF,DUMP_DM,DONE), HALT_WORD default,
//   REG_COUNT=32. Single FSM module; no sub-module (counters inline).
// TESTING
//  prog_len=2, words 20100002,22100003 with ld_valid gaps -> exactly 2 writes, addr 0 then 4.
//  Run addi program then HALT_WORD at addr 8 -> DRAIN 4 cycles; dump $16=5, others 0; timeout=0.
//  Program without halt -> stop at cycle_count=999, timeout=1, dump still 32 words.
//  dump_ready low 3 cycles at idx 7 -> dump_data/dump_idx held constant, no skipped index.
//  reset asserted in LOAD after 1 word -> next cycle IDLE, pc_reset=1, ld_ready=0, busy=0.
//  DMEM_DUMP_EN: sw $16,0($0) run -> after r31, mem word 0 = 5, 16 mem words, then done=1.

Source files
------------

// File: rtl/proc_ctrl_pkg.sv
// Shared types and constants for the processor run controller.
// Holds the sequencer state enum, the default halt word and the register count.
package proc_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      RUN,
      DRAIN,
      DUMP_RF,
      DUMP_DM,
      DONE
   } state_t;

   // syscall encoding ends a run
   localparam logic [31:0] DEF_HALT_WORD = 32'h0000000C;

   localparam int REG_COUNT = 32;

endpackage

// File: rtl/proc_run_controller.sv
// Top-level sequencer for the MIPS datapath: load program, run, drain, dump.
// Ports: start/prog_len command; ld_* program stream in; imem_*/init_sel/pc_*
//   drive the fetch side; rf_dbg_* (and dm_dbg_* with DMEM_DUMP_EN) read
//   state back; dump_* stream it out; cycle_count/busy/done/timeout status.
// Macro DMEM_DUMP_EN: when defined, data memory is streamed after r31.
module proc_run_controller
   import proc_ctrl_pkg::*;
#(
   parameter int          PROG_LEN_W   = 8,
   parameter logic [15:0] MAX_CYCLES   = 16'd1000,
   parameter logic [31:0] HALT_WORD    = DEF_HALT_WORD,
   parameter int          DRAIN_CYCLES = 4,
   parameter int          DMEM_WORDS   = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [PROG_LEN_W-1:0] prog_len,
   input  logic                  ld_valid,
   input  logic [31:0]           ld_data,
   output logic                  ld_ready,
   output logic [31:0]           imem_addr,
   output logic [31:0]           imem_wdata,
   output logic                  imem_write,
   output logic                  imem_read,
   output logic                  init_sel,
   output logic                  pc_reset,
   output logic                  pc_write,
   input  logic [31:0]           instr,
   output logic                  rf_dbg_sel,
   output logic [4:0]            rf_dbg_addr,
   input  logic [31:0]           rf_dbg_data,
`ifdef DMEM_DUMP_EN
   output logic                  dm_dbg_sel,
   output logic [31:0]           dm_dbg_addr,
   input  logic [31:0]           dm_dbg_data,
`endif
   output logic                  dump_valid,
   input  logic                  dump_ready,
   output logic [31:0]           dump_data,
   output logic [7:0]            dump_idx,
   output logic [15:0]           cycle_count,
   output logic                  busy,
   output logic                  done,
   output logic                  timeout
);

   localparam int AW_PAD = 30 - PROG_LEN_W;
   localparam logic [PROG_LEN_W-1:0] ONE_W = 1;
   localparam logic [7:0] RF_LAST    = 8'(REG_COUNT - 1);
   localparam logic [7:0] DRAIN_LAST = 8'(DRAIN_CYCLES - 1);
`ifdef DMEM_DUMP_EN
   localparam logic [7:0] DM_LAST    = 8'(DMEM_WORDS - 1);
`endif

   state_t state, state_n;

   logic [PROG_LEN_W-1:0] prog_q;
   logic [PROG_LEN_W-1:0] widx;
   logic [7:0]            idx;

   logic last_word;
   logic halt_hit;
   logic limit_hit;

   assign last_word = (widx == prog_q - ONE_W);
   assign halt_hit  = (instr == HALT_WORD);
   assign limit_hit = (cycle_count == MAX_CYCLES - 16'd1);

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_n;
   end

   always_comb begin
      state_n     = state;
      ld_ready    = 1'b0;
      imem_addr   = '0;
      imem_wdata  = '0;
      imem_write  = 1'b0;
      imem_read   = 1'b0;
      init_sel    = 1'b0;
      pc_reset    = 1'b0;
      pc_write    = 1'b0;
      rf_dbg_sel  = 1'b0;
      rf_dbg_addr = '0;
`ifdef DMEM_DUMP_EN
      dm_dbg_sel  = 1'b0;
      dm_dbg_addr = '0;
`endif
      dump_valid  = 1'b0;
      dump_data   = '0;
      dump_idx    = '0;
      busy        = 1'b1;
      done        = 1'b0;
      unique case (state)
         IDLE: begin
            busy     = 1'b0;
            init_sel = 1'b1;
            pc_reset = 1'b1;
            if (start) state_n = (prog_len == '0) ? RUN : LOAD;
         end
         LOAD: begin
            ld_ready  = 1'b1;
            init_sel  = 1'b1;
            pc_reset  = 1'b1;
            imem_addr = {{AW_PAD{1'b0}}, widx, 2'b00};
            if (ld_valid) begin
               imem_write = 1'b1;
               imem_wdata = ld_data;
               if (last_word) state_n = RUN;
            end
         end
         RUN: begin
            pc_write  = 1'b1;
            imem_read = 1'b1;
            if (halt_hit || limit_hit) state_n = DRAIN;
         end
         DRAIN: begin
            imem_read = 1'b1;
            if (idx == DRAIN_LAST) state_n = DUMP_RF;
         end
         DUMP_RF: begin
            rf_dbg_sel  = 1'b1;
            rf_dbg_addr = idx[4:0];
            dump_valid  = 1'b1;
            dump_data   = rf_dbg_data;
            dump_idx    = idx;
            if (dump_ready && idx == RF_LAST) begin
`ifdef DMEM_DUMP_EN
               state_n = DUMP_DM;
`else
               state_n = DONE;
`endif
            end
         end
`ifdef DMEM_DUMP_EN
         DUMP_DM: begin
            dm_dbg_sel  = 1'b1;
            dm_dbg_addr = {22'b0, idx, 2'b00};
            dump_valid  = 1'b1;
            dump_data   = dm_dbg_data;
            dump_idx    = idx;
            if (dump_ready && idx == DM_LAST) state_n = DONE;
         end
`endif
         DONE: begin
            busy     = 1'b0;
            done     = 1'b1;
            pc_reset = 1'b1;
            if (start) state_n = (prog_len == '0) ? RUN : LOAD;
         end
         default: state_n = IDLE;
      endcase
   end

   // cycle_count advances only on RUN cycles that stay in RUN, so a
   // forced stop leaves it at MAX_CYCLES-1.  idx is reused as the drain
   // timer and as the dump index; it is zeroed on every state exit.
   always_ff @(posedge clk) begin
      if (reset) begin
         prog_q      <= '0;
         widx        <= '0;
         idx         <= '0;
         cycle_count <= '0;
         timeout     <= 1'b0;
      end else begin
         unique case (state)
            IDLE, DONE: begin
               if (start) begin
                  prog_q      <= prog_len;
                  widx        <= '0;
                  idx         <= '0;
                  cycle_count <= '0;
                  timeout     <= 1'b0;
               end
            end
            LOAD: begin
               if (ld_valid && !last_word) widx <= widx + ONE_W;
            end
            RUN: begin
               if (halt_hit) begin
                  // halt wins over the limit
               end else if (limit_hit) begin
                  timeout <= 1'b1;
               end else begin
                  cycle_count <= cycle_count + 16'd1;
               end
            end
            DRAIN: begin
               idx <= (idx == DRAIN_LAST) ? '0 : idx + 8'd1;
            end
            DUMP_RF: begin
               if (dump_ready) idx <= (idx == RF_LAST) ? '0 : idx + 8'd1;
            end
`ifdef DMEM_DUMP_EN
            DUMP_DM: begin
               if (dump_ready) idx <= (idx == DM_LAST) ? '0 : idx + 8'd1;
            end
`endif
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_proc_run_controller.sv
// Self-checking bench for proc_run_controller with a small fetch/regfile model.
// Table-driven load phase, hand sequences, and randomized program runs.
module tb_proc_run_controller;
   import proc_ctrl_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [7:0]  prog_len;
   logic        ld_valid;
   logic [31:0] ld_data;
   logic        ld_ready;
   logic [31:0] imem_addr;
   logic [31:0] imem_wdata;
   logic        imem_write;
   logic        imem_read;
   logic        init_sel;
   logic        pc_reset;
   logic        pc_write;
   logic [31:0] instr;
   logic        rf_dbg_sel;
   logic [4:0]  rf_dbg_addr;
   logic [31:0] rf_dbg_data;
`ifdef DMEM_DUMP_EN
   logic        dm_dbg_sel;
   logic [31:0] dm_dbg_addr;
   logic [31:0] dm_dbg_data;
   logic [31:0] exp_dm[$];
`endif
   logic        dump_valid;
   logic        dump_ready;
   logic [31:0] dump_data;
   logic [7:0]  dump_idx;
   logic [15:0] cycle_count;
   logic        busy;
   logic        done;
   logic        timeout;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   proc_run_controller dut (
      .clk(clk), .reset(reset), .start(start), .prog_len(prog_len),
      .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
      .imem_addr(imem_addr), .imem_wdata(imem_wdata),
      .imem_write(imem_write), .imem_read(imem_read),
      .init_sel(init_sel), .pc_reset(pc_reset), .pc_write(pc_write),
      .instr(instr), .rf_dbg_sel(rf_dbg_sel),
      .rf_dbg_addr(rf_dbg_addr), .rf_dbg_data(rf_dbg_data),
`ifdef DMEM_DUMP_EN
      .dm_dbg_sel(dm_dbg_sel), .dm_dbg_addr(dm_dbg_addr),
      .dm_dbg_data(dm_dbg_data),
`endif
      .dump_valid(dump_valid), .dump_ready(dump_ready),
      .dump_data(dump_data), .dump_idx(dump_idx),
      .cycle_count(cycle_count), .busy(busy), .done(done),
      .timeout(timeout)
   );

   // ---- single-cycle datapath stand-in (imem, PC, regfile, dmem) ----
   logic [31:0] mem [256];
   logic [31:0] regs [32];
   logic [31:0] dmem [16];
   logic [31:0] pc;
   logic [31:0] ea;
   logic        wipe_im;
   logic        wipe_rf;

   assign instr = init_sel ? mem[imem_addr[9:2]] : mem[pc[9:2]];
   assign rf_dbg_data = regs[rf_dbg_addr];
   assign ea = regs[instr[25:21]] + {{16{instr[15]}}, instr[15:0]};
`ifdef DMEM_DUMP_EN
   assign dm_dbg_data = dmem[dm_dbg_addr[5:2]];
`endif

   always @(posedge clk) begin
      if (wipe_im) begin
         for (int i = 0; i < 256; i++) mem[i] <= '0;
      end else if (imem_write) begin
         mem[imem_addr[9:2]] <= imem_wdata;
      end
      if (pc_reset)      pc <= '0;
      else if (pc_write) pc <= pc + 32'd4;
      if (wipe_rf) begin
         for (int i = 0; i < 32; i++) regs[i] <= '0;
         for (int i = 0; i < 16; i++) dmem[i] <= '0;
      end else if (pc_write) begin
         if (instr[31:26] == 6'h08 && instr[20:16] != 5'd0)
            regs[instr[20:16]] <= ea;
         if (instr[31:26] == 6'h2b)
            dmem[ea[5:2]] <= regs[instr[20:16]];
      end
   end

   // ---- helpers ----
   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic zero_rf(output logic [31:0] q[$]);
      q = {};
      for (int i = 0; i < 32; i++) q.push_back(32'd0);
   endtask

   task automatic load_prog(input logic [31:0] w[$], input bit gaps);
      int k = 0;
      int cyc = 0;
      start = 1'b1;
      prog_len = 8'(w.size());
      tick;
      start = 1'b0;
      chk("busy_after_start", 32'(busy), 32'd1);
      chk("done_after_start", 32'(done), 32'd0);
      chk("timeout_cleared", 32'(timeout), 32'd0);
      while (k < w.size() && cyc < 500) begin
         ld_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
         ld_data  = w[k];
         #1;
         chk("ld_ready", 32'(ld_ready), 32'd1);
         chk("imem_write", 32'(imem_write), 32'(ld_valid));
         if (ld_valid) begin
            chk("imem_addr", imem_addr, 32'(k * 4));
            chk("imem_wdata", imem_wdata, w[k]);
            k++;
         end
         cyc++;
         tick;
      end
      ld_valid = 1'b0;
      if (k != w.size()) chk("load_budget", 32'(k), 32'(w.size()));
      chk("no_extra_write", 32'(imem_write), 32'd0);
   endtask

   task automatic collect_dump(input logic [31:0] exp[$], input bit stall7,
                               input bit rnd);
      int got = 0;
      int cyc = 0;
      int stalls = 3;
      bit held = 1'b0;
      logic [31:0] pd;
      logic [7:0]  pi;
      while (got < exp.size() && cyc < 2000) begin
         if (stall7 && dump_idx == 8'd7 && stalls > 0) begin
            dump_ready = 1'b0;
            stalls--;
         end else begin
            dump_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         end
         #1;
         chk("dump_valid", 32'(dump_valid), 32'd1);
         if (held) begin
            chk("hold_data", dump_data, pd);
            chk("hold_idx", 32'(dump_idx), 32'(pi));
         end
         if (dump_ready) begin
            chk("dump_idx", 32'(dump_idx), 32'(got));
            chk("dump_data", dump_data, exp[got]);
            got++;
         end
         held = dump_valid && !dump_ready;
         pd   = dump_data;
         pi   = dump_idx;
         cyc++;
         tick;
      end
      dump_ready = 1'b0;
      if (got != exp.size()) chk("dump_budget", 32'(got), 32'(exp.size()));
   endtask

   task automatic finish_run(input int e_run, input int e_cc, input bit e_to,
                             input logic [31:0] erf[$], input bit stall7,
                             input bit rnd);
      int n = 0;
      while (pc_write && n < 1200) begin
         n++;
         tick;
      end
      chk("run_cycles", 32'(n), 32'(e_run));
      chk("cycle_count", 32'(cycle_count), 32'(e_cc));
      chk("timeout", 32'(timeout), 32'(e_to));
      n = 0;
      while (!dump_valid && n < 20) begin
         n++;
         tick;
      end
      chk("drain_cycles", 32'(n), 32'd4);
      chk("rf_dbg_sel", 32'(rf_dbg_sel), 32'd1);
      collect_dump(erf, stall7, rnd);
`ifdef DMEM_DUMP_EN
      chk("dm_dbg_sel", 32'(dm_dbg_sel), 32'd1);
      collect_dump(exp_dm, 1'b0, rnd);
`endif
      chk("done_end", 32'(done), 32'd1);
      chk("busy_end", 32'(busy), 32'd0);
      chk("pc_reset_end", 32'(pc_reset), 32'd1);
   endtask

   typedef struct {
      logic        st;
      logic [7:0]  plen;
      logic        vld;
      logic [31:0] data;
      logic        e_rdy;
      logic        e_wr;
      logic [31:0] e_addr;
      logic        e_busy;
   } vec_t;

   initial begin
      vec_t tv[6];
      logic [31:0] erf[$];
      logic [31:0] w[$];

      reset = 1'b1; start = 1'b0; prog_len = '0;
      ld_valid = 1'b0; ld_data = '0; dump_ready = 1'b0;
      wipe_im = 1'b1; wipe_rf = 1'b1;
`ifdef DMEM_DUMP_EN
      exp_dm = {};
      for (int i = 0; i < 16; i++) exp_dm.push_back(32'd0);
`endif
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0; wipe_im = 1'b0; wipe_rf = 1'b0;

      // reset state
      chk("rst_pc_reset", 32'(pc_reset), 32'd1);
      chk("rst_ld_ready", 32'(ld_ready), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_timeout", 32'(timeout), 32'd0);
      chk("rst_cycle_count", 32'(cycle_count), 32'd0);
      chk("rst_pc_write", 32'(pc_write), 32'd0);
      chk("rst_imem_write", 32'(imem_write), 32'd0);
      chk("rst_dump_valid", 32'(dump_valid), 32'd0);

      // two-word load with ld_valid gaps; no halt follows -> timeout
      tv[0] = '{1'b1, 8'd2, 1'b0, 32'h0, 1'b0, 1'b0, 32'd0, 1'b0};
      tv[1] = '{1'b0, 8'd0, 1'b0, 32'h0, 1'b1, 1'b0, 32'd0, 1'b1};
      tv[2] = '{1'b0, 8'd0, 1'b1, 32'h20100002, 1'b1, 1'b1, 32'd0, 1'b1};
      tv[3] = '{1'b0, 8'd0, 1'b0, 32'h0, 1'b1, 1'b0, 32'd4, 1'b1};
      tv[4] = '{1'b0, 8'd0, 1'b0, 32'h0, 1'b1, 1'b0, 32'd4, 1'b1};
      tv[5] = '{1'b0, 8'd0, 1'b1, 32'h22100003, 1'b1, 1'b1, 32'd4, 1'b1};
      for (int i = 0; i < 6; i++) begin
         start = tv[i].st; prog_len = tv[i].plen;
         ld_valid = tv[i].vld; ld_data = tv[i].data;
         #1;
         chk($sformatf("tv%0d_ld_ready", i), 32'(ld_ready), 32'(tv[i].e_rdy));
         chk($sformatf("tv%0d_write", i), 32'(imem_write), 32'(tv[i].e_wr));
         chk($sformatf("tv%0d_busy", i), 32'(busy), 32'(tv[i].e_busy));
         if (tv[i].e_rdy) chk($sformatf("tv%0d_addr", i), imem_addr, tv[i].e_addr);
         if (tv[i].e_wr) chk($sformatf("tv%0d_wdata", i), imem_wdata, tv[i].data);
         tick;
      end
      start = 1'b0; ld_valid = 1'b0;
      chk("run_pc_write", 32'(pc_write), 32'd1);
      chk("run_init_sel", 32'(init_sel), 32'd0);
      chk("run_ld_ready", 32'(ld_ready), 32'd0);
      chk("run_imem_read", 32'(imem_read), 32'd1);
      zero_rf(erf);
      erf[16] = 32'd5;
      finish_run(1000, 999, 1'b1, erf, 1'b0, 1'b0);

      // addi program with halt at addr 8, dump stalled at idx 7
      wipe_rf = 1'b1; tick; wipe_rf = 1'b0;
      w = {32'h20100002, 32'h22100003, DEF_HALT_WORD};
      load_prog(w, 1'b1);
      finish_run(3, 2, 1'b0, erf, 1'b1, 1'b0);

      // prog_len==0 reruns existing imem straight from DONE
      start = 1'b1; prog_len = 8'd0;
      tick;
      start = 1'b0;
      chk("len0_pc_write", 32'(pc_write), 32'd1);
      chk("len0_ld_ready", 32'(ld_ready), 32'd0);
      chk("len0_done", 32'(done), 32'd0);
      finish_run(3, 2, 1'b0, erf, 1'b0, 1'b1);

      // random addi programs, random handshakes
      for (int it = 0; it < 3; it++) begin
         int n;
         wipe_rf = 1'b1; tick; wipe_rf = 1'b0;
         n = $urandom_range(1, 6);
         w = {};
         zero_rf(erf);
         for (int k = 0; k < n; k++) begin
            logic [4:0]  rs, rt;
            logic [15:0] imm;
            rs  = 5'($urandom_range(0, 31));
            rt  = 5'($urandom_range(1, 31));
            imm = 16'($urandom_range(0, 65535));
            w.push_back({6'h08, rs, rt, imm});
            erf[rt] = erf[rs] + {{16{imm[15]}}, imm};
         end
         w.push_back(DEF_HALT_WORD);
         chk("done_before_restart", 32'(done), 32'd1);
         load_prog(w, 1'b1);
         finish_run(n + 1, n, 1'b0, erf, 1'b0, 1'b1);
      end

`ifdef DMEM_DUMP_EN
      // store $16 to mem word 0, dumped after the regfile
      wipe_rf = 1'b1; tick; wipe_rf = 1'b0;
      w = {32'h20100002, 32'h22100003, 32'hAC100000, DEF_HALT_WORD};
      zero_rf(erf);
      erf[16] = 32'd5;
      exp_dm[0] = 32'd5;
      load_prog(w, 1'b0);
      finish_run(4, 3, 1'b0, erf, 1'b0, 1'b1);
`endif

      // reset in the middle of LOAD
      start = 1'b1; prog_len = 8'd3;
      tick;
      start = 1'b0; ld_valid = 1'b1; ld_data = 32'h20100002;
      tick;
      ld_valid = 1'b0; reset = 1'b1;
      tick;
      chk("mid_rst_pc_reset", 32'(pc_reset), 32'd1);
      chk("mid_rst_ld_ready", 32'(ld_ready), 32'd0);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_write", 32'(imem_write), 32'd0);
      reset = 1'b0;
      tick;
      chk("mid_rst_idle", 32'(busy), 32'd0);
      chk("mid_rst_cc", 32'(cycle_count), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
